// File: rtl/output_port_alloc.sv
`default_nettype none
// ============================================================================
// Module      : output_port_alloc
// Description : Output-port allocator for a torus router. Grants one
//               requester per cycle, holds the port for the duration of a
//               multi-flit packet, and tracks downstream credits.
//               Optional macro FARTHEST_FIRST_ARB_EN enables prio-based
//               arbitration in IDLE; otherwise IDLE arbitration is pure
//               round-robin. NREQ must not exceed 8 (3-bit grant_idx).
// Revision    : 1.0 - initial release
// ============================================================================
module output_port_alloc #(
  parameter int NREQ    = 7,
  parameter int PW      = 8,
  parameter int CREDITS = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NREQ-1:0]              req,
  input  logic [NREQ-1:0]              is_head,
  input  logic [NREQ-1:0]              is_tail,
  input  logic [NREQ*PW-1:0]           prio,
  input  logic                         credit_ret,
  output logic [NREQ-1:0]              grant,
  output logic [2:0]                   grant_idx,
  output logic                         locked,
  output logic [$clog2(CREDITS+1)-1:0] credit_cnt
);

  localparam int            CW            = $clog2(CREDITS + 1);
  localparam logic [CW-1:0] C_CREDITS_MAX = CW'(CREDITS);
  localparam logic [3:0]    C_NREQ        = 4'(NREQ);
  localparam logic [2:0]    C_LAST_IDX    = 3'(NREQ - 1);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [2:0]      r_owner;
  logic [2:0]      r_rr_ptr;
  logic [CW-1:0]   r_credit;

  logic [NREQ-1:0] w_elig;
  logic            w_found;
  logic [2:0]      w_winner;
  logic [3:0]      w_scan;
  logic [2:0]      w_idx;
  logic            w_fire;
  logic [2:0]      w_rr_nxt;

  assign w_elig = req & is_head;

`ifdef FARTHEST_FIRST_ARB_EN
  logic [PW-1:0] w_prio [NREQ];
  logic [PW-1:0] w_best;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_prio
    assign w_prio[gi] = prio[gi*PW +: PW];
  end

  // Scan from rr_ptr; strict '>' keeps the earliest requester among equal prio.
  always_comb begin
    w_found  = 1'b0;
    w_winner = 3'd0;
    w_best   = '0;
    w_scan   = 4'd0;
    w_idx    = 3'd0;
    for (int k = 0; k < NREQ; k++) begin
      w_scan = {1'b0, r_rr_ptr} + 4'(k);
      if (w_scan >= C_NREQ) w_scan = w_scan - C_NREQ;
      w_idx = w_scan[2:0];
      if (w_elig[w_idx] && (!w_found || (w_prio[w_idx] > w_best))) begin
        w_found  = 1'b1;
        w_winner = w_idx;
        w_best   = w_prio[w_idx];
      end
    end
  end
`else
  logic w_unused_prio;
  assign w_unused_prio = ^prio;

  // Pure round-robin: first eligible requester at or after rr_ptr.
  always_comb begin
    w_found  = 1'b0;
    w_winner = 3'd0;
    w_scan   = 4'd0;
    w_idx    = 3'd0;
    for (int k = 0; k < NREQ; k++) begin
      w_scan = {1'b0, r_rr_ptr} + 4'(k);
      if (w_scan >= C_NREQ) w_scan = w_scan - C_NREQ;
      w_idx = w_scan[2:0];
      if (w_elig[w_idx] && !w_found) begin
        w_found  = 1'b1;
        w_winner = w_idx;
      end
    end
  end
`endif

  assign w_rr_nxt = (w_winner == C_LAST_IDX) ? 3'd0 : (w_winner + 3'd1);

  // Grant and next-state decode; nothing transfers without a credit or in reset.
  always_comb begin
    grant       = '0;
    w_fire      = 1'b0;
    w_state_nxt = r_state;
    if (!rst && (r_credit != '0)) begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            grant[w_winner] = 1'b1;
            w_fire          = 1'b1;
            if (!is_tail[w_winner]) w_state_nxt = ST_LOCKED;
          end
        end
        ST_LOCKED: begin
          if (req[r_owner]) begin
            grant[r_owner] = 1'b1;
            w_fire         = 1'b1;
            if (is_tail[r_owner]) w_state_nxt = ST_IDLE;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // State register; reset drops any packet in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Owner and round-robin pointer update only on a new-packet (IDLE) grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner  <= 3'd0;
      r_rr_ptr <= 3'd0;
    end else if (w_fire && (r_state == ST_IDLE)) begin
      r_owner  <= w_winner;
      r_rr_ptr <= w_rr_nxt;
    end
  end

  // Credit counter: grant consumes, credit_ret refunds, saturating at CREDITS.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_credit <= C_CREDITS_MAX;
    end else begin
      case ({w_fire, credit_ret})
        2'b10:   r_credit <= r_credit - CW'(1);
        2'b01:   if (r_credit != C_CREDITS_MAX) r_credit <= r_credit + CW'(1);
        default: r_credit <= r_credit;
      endcase
    end
  end

  assign locked     = (r_state == ST_LOCKED);
  assign grant_idx  = r_owner;
  assign credit_cnt = r_credit;

endmodule
`default_nettype wire

// File: tb/tb_output_port_alloc.sv
`default_nettype none
// ============================================================================
// Module      : tb_output_port_alloc
// Description : Self-checking bench for output_port_alloc: directed scenarios
//               plus randomized traffic against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_output_port_alloc;

  localparam int NREQ    = 7;
  localparam int PW      = 8;
  localparam int CREDITS = 4;
  localparam int CW      = $clog2(CREDITS + 1);

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [NREQ-1:0]    req = '0;
  logic [NREQ-1:0]    is_head = '0;
  logic [NREQ-1:0]    is_tail = '0;
  logic [NREQ*PW-1:0] prio = '0;
  logic               credit_ret = 1'b0;
  logic [NREQ-1:0]    grant;
  logic [2:0]         grant_idx;
  logic               locked;
  logic [CW-1:0]      credit_cnt;

  output_port_alloc #(.NREQ(NREQ), .PW(PW), .CREDITS(CREDITS)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .is_head    (is_head),
    .is_tail    (is_tail),
    .prio       (prio),
    .credit_ret (credit_ret),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .locked     (locked),
    .credit_cnt (credit_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: packet lock, owner, rotation start, credits.
  int m_locked = 0;
  int m_owner  = 0;
  int m_rr     = 0;
  int m_cred   = CREDITS;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [NREQ*PW-1:0] pset(input logic [NREQ*PW-1:0] base, input int i, input int v);
    logic [NREQ*PW-1:0] r;
    r = base;
    r[i*PW +: PW] = PW'(v);
    return r;
  endfunction

  // New-packet winner: highest prio (or all equal when prio is ignored),
  // ties broken by smallest cyclic distance from the rotation start.
  function automatic int pick(input logic [NREQ-1:0] r, input logic [NREQ-1:0] h,
                              input logic [NREQ*PW-1:0] p);
    int best, bestp, bestd, d, pv;
    best = -1; bestp = -1; bestd = NREQ;
    for (int i = 0; i < NREQ; i++) begin
      if (r[i] && h[i]) begin
        d = (i - m_rr + NREQ) % NREQ;
`ifdef FARTHEST_FIRST_ARB_EN
        pv = int'(p[i*PW +: PW]);
`else
        pv = 0;
`endif
        if ((pv > bestp) || ((pv == bestp) && (d < bestd))) begin
          best = i; bestp = pv; bestd = d;
        end
      end
    end
    return best;
  endfunction

  // One cycle: drive at negedge, check shortly after, then advance the model.
  task automatic step(input logic [NREQ-1:0] r, input logic [NREQ-1:0] h,
                      input logic [NREQ-1:0] t, input logic [NREQ*PW-1:0] p,
                      input logic cr, output logic [NREQ-1:0] g);
    int w;
    logic [NREQ-1:0] eg;
    @(negedge clk);
    req = r; is_head = h; is_tail = t; prio = p; credit_ret = cr;
    #1;
    if (m_cred == 0)   w = -1;
    else if (m_locked) w = r[m_owner] ? m_owner : -1;
    else               w = pick(r, h, p);
    eg = '0;
    if (w >= 0) eg[w] = 1'b1;
    g = grant;
    chk("grant", 32'(grant), 32'(eg));
    chk("locked", 32'(locked), 32'(m_locked));
    chk("grant_idx", 32'(grant_idx), 32'(m_owner));
    chk("credit_cnt", 32'(credit_cnt), 32'(m_cred));
    if (w >= 0) begin
      if (m_locked == 0) begin
        m_owner = w;
        m_rr    = (w + 1) % NREQ;
        if (!t[w]) m_locked = 1;
      end else if (t[w]) begin
        m_locked = 0;
      end
    end
    m_cred = m_cred - ((w >= 0) ? 1 : 0) + (cr ? 1 : 0);
    if (m_cred > CREDITS) m_cred = CREDITS;
  endtask

  // Asynchronous reset applied mid-cycle; outputs must clear before any edge.
  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_credit", 32'(credit_cnt), 32'(CREDITS));
    chk("rst_idx", 32'(grant_idx), 32'd0);
    m_locked = 0; m_owner = 0; m_rr = 0; m_cred = CREDITS;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    logic [NREQ-1:0]    g;
    logic [NREQ-1:0]    r, h, t;
    logic [NREQ*PW-1:0] p;
    logic               cr;
    int                 ngr;

    // Bring-up reset with requests pending: grant must stay low.
    req = 7'b1111111; is_head = 7'b1111111; is_tail = 7'b1111111;
    do_reset();

`ifdef FARTHEST_FIRST_ARB_EN
    // Higher prio wins first, then the remaining requester.
    p = pset(pset('0, 0, 5), 1, 9);
    step(7'b0000011, 7'b0000011, 7'b0000011, p, 1'b0, g);
    chk("prio_first", 32'(g), 32'b0000010);
    step(7'b0000011, 7'b0000011, 7'b0000011, p, 1'b0, g);
    chk("prio_second", 32'(g), 32'b0000001);
    step('0, '0, '0, '0, 1'b0, g);
`else
    // Prio ignored: rotation from 0 picks requester 0 despite its low prio.
    p = pset(pset('0, 0, 1), 6, 200);
    step(7'b1000001, 7'b1000001, 7'b1000001, p, 1'b0, g);
    chk("rr_ignores_prio", 32'(g), 32'b0000001);
`endif

    // Packet lock: requester 3 holds the port for 4 flits over requester 0.
    do_reset();
    step(7'b0000001, 7'b0000001, 7'b0000001, '0, 1'b1, g);
    p = pset('0, 3, 7);
    step(7'b0001001, 7'b0001001, 7'b0000001, p, 1'b1, g);
    chk("pkt_head", 32'(g), 32'b0001000);
    for (int i = 0; i < 2; i++) begin
      step(7'b0001001, 7'b0000001, 7'b0000001, p, 1'b1, g);
      chk("pkt_body", 32'(g), 32'b0001000);
    end
    step(7'b0001001, 7'b0000001, 7'b0001001, p, 1'b1, g);
    chk("pkt_tail", 32'(g), 32'b0001000);
    step(7'b0000001, 7'b0000001, 7'b0000001, p, 1'b1, g);
    chk("pkt_after", 32'(g), 32'b0000001);

    // Credit exhaustion on a 6-flit packet, then a single returned credit.
    do_reset();
    ngr = 0;
    for (int i = 0; i < 6; i++) begin
      step(7'b0000100, (i == 0) ? 7'b0000100 : 7'b0, '0, '0, 1'b0, g);
      if (g != '0) ngr++;
    end
    chk("credit_grants", 32'(ngr), 32'd4);
    step(7'b0000100, '0, '0, '0, 1'b1, g);
    chk("credit_ret_same_cycle", 32'(g), 32'd0);
    step(7'b0000100, '0, '0, '0, 1'b0, g);
    chk("credit_ret_next", 32'(g), 32'b0000100);

    // Equal prio ties rotate 2, 4, 6, 2.
    do_reset();
    p = pset(pset(pset('0, 2, 3), 4, 3), 6, 3);
    step(7'b1010100, 7'b1010100, 7'b1010100, p, 1'b1, g);
    chk("tie_0", 32'(g), 32'b0000100);
    step(7'b1010100, 7'b1010100, 7'b1010100, p, 1'b1, g);
    chk("tie_1", 32'(g), 32'b0010000);
    step(7'b1010100, 7'b1010100, 7'b1010100, p, 1'b1, g);
    chk("tie_2", 32'(g), 32'b1000000);
    step(7'b1010100, 7'b1010100, 7'b1010100, p, 1'b1, g);
    chk("tie_3", 32'(g), 32'b0000100);

    // Reset while locked on owner 5 abandons the packet.
    do_reset();
    step(7'b0100000, 7'b0100000, '0, '0, 1'b0, g);
    step(7'b0100000, '0, '0, '0, 1'b0, g);
    chk("lock_owner5", 32'(locked), 32'd1);
    do_reset();
    step(7'b0100010, 7'b0000010, 7'b0000010, '0, 1'b0, g);
    chk("post_rst_head", 32'(g), 32'b0000010);

    // Randomized traffic; credit return rate varies to exercise starvation.
    do_reset();
    for (int n = 0; n < 800; n++) begin
      r  = NREQ'($urandom | $urandom);
      h  = NREQ'($urandom);
      t  = NREQ'($urandom);
      p  = '0;
      for (int i = 0; i < NREQ; i++) p = pset(p, i, int'($urandom_range(0, 3)));
      cr = ($urandom_range(0, 9) < ((n < 400) ? 3 : 7));
      step(r, h, t, p, cr, g);
      if ($urandom_range(0, 99) == 0) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/output_port_alloc.md
OUTPUT_PORT_ALLOC -- requirements
Module: output_port_alloc

Interface
REQ-001 Parameter NREQ, default 7; number of requesters (6 torus input ports plus injection).
REQ-002 Parameter PW, default 8; width of the per-requester priority (cmp) field.
REQ-003 Parameter CREDITS, default 4; downstream buffer depth in flits.
REQ-004 clk  input  1; the only clock, rising edge.
REQ-005 rst  input  1; asynchronous, active-high reset.
REQ-006 req  input  NREQ; requester i has a valid flit for this output port.
REQ-007 is_head  input  NREQ; requester i's current flit is a head or single flit.
REQ-008 is_tail  input  NREQ; requester i's current flit is a tail or single flit.
REQ-009 prio  input  NREQ*PW; packed priority fields, requester i at bits [i*PW+PW-1 : i*PW].
REQ-010 credit_ret  input  1; the downstream router freed one buffer slot.
REQ-011 grant  output  NREQ; one-hot, or zero when no flit transfers this cycle.
REQ-012 grant_idx  output  3; binary index of the current or last owner.
REQ-013 locked  output  1; the port is held by a packet in flight.
REQ-014 credit_cnt  output  $clog2(CREDITS+1); number of available downstream slots.

Function
REQ-015 The block SHALL have two states, IDLE and LOCKED, with the state held in a register.
REQ-016 grant SHALL be combinational from the registered state, req, is_head, is_tail, prio and credit_cnt. The transfer happens in the same cycle the grant is asserted.
REQ-017 In IDLE, eligible requesters SHALL be those with req=1 and is_head=1. The block SHALL grant one eligible requester only if credit_cnt>0.
REQ-018 In IDLE, the winner SHALL be the eligible requester with the highest prio. Ties SHALL go to the first requester at or after rr_ptr, scanning cyclically.
REQ-019 An IDLE grant with is_tail=0 SHALL move the state to LOCKED with owner=winner. A single-flit grant SHALL leave the state in IDLE.
REQ-020 In LOCKED, grant SHALL be asserted only to the owner, and only when req[owner]=1 and credit_cnt>0. Other requesters SHALL be ignored.
REQ-021 In LOCKED, a granted flit with is_tail[owner]=1 SHALL return the state to IDLE on that clock edge.
REQ-022 On every IDLE grant, rr_ptr SHALL become (winner+1) mod NREQ.
REQ-023 credit_cnt SHALL change as follows: -1 on a grant, +1 on credit_ret, unchanged when both occur, and never exceed CREDITS or go below 0.
REQ-024 A credit_ret while credit_cnt=CREDITS and no grant SHALL be ignored.
REQ-025 When credit_cnt=0 and credit_ret=1 in the same cycle, no grant SHALL be issued that cycle; the returned credit becomes usable next cycle.
REQ-026 locked SHALL equal (state==LOCKED), and grant_idx SHALL hold the owner or last winner.

Reset
REQ-027 On rst=1, asynchronously: state=IDLE, rr_ptr=0, owner=0, grant_idx=0, credit_cnt=CREDITS, locked=0. grant SHALL be 0 while rst=1.
REQ-028 Reset asserted mid-packet SHALL abandon the lock. The first cycle after release SHALL be IDLE arbitration.

Configuration
REQ-029 Macro FARTHEST_FIRST_ARB_EN defined: IDLE arbitration SHALL use prio per REQ-018.
REQ-030 Macro FARTHEST_FIRST_ARB_EN undefined: prio SHALL be ignored and IDLE arbitration SHALL be pure round-robin from rr_ptr. All other behaviour is unchanged.

Verification
REQ-031 Reset, then req=0000011, both single flits, prio 5 and 9, macro on -> grant=0000010; next cycle grant=0000001; credit_cnt 4->3->2.
REQ-032 Requester 3 sends head, 2 bodies, tail while requester 0 holds a head -> grant=0001000 for 4 cycles, locked=1 for 3 cycles, then grant=0000001.
REQ-033 CREDITS=4 with no credit_ret and a 6-flit packet -> 4 grants, then grant=0 with credit_cnt=0. A credit_ret pulse -> one more grant one cycle later.
REQ-034 Equal prio=3 on requesters 2, 4 and 6, all single flits, held continuously -> grant order 2, 4, 6, 2.
REQ-035 rst pulsed while LOCKED on owner 5 -> locked=0 and credit_cnt=4 immediately; the next head from requester 1 is granted.
REQ-036 Macro off, prio 1 on requester 0 and 200 on requester 6, rr_ptr=0 -> grant=0000001.
